// File: rtl/serial_subtractor8_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor8_if
// Description : Start/done handshake and operand/result bundle for the
//               bit-serial subtractor.
// Revision    : 1.0  initial release
// ============================================================================
interface serial_subtractor8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, overflow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor8.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor8
// Description : Bit-serial two's-complement subtractor, diff = a - b - bin,
//               LSB first, one bit per clock, start/done handshake.
// Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor8_if.slave  bus
);

    localparam int                 c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_brw;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-2:0]     r_res;
    logic [WIDTH-1:0]     r_diff;
    logic                 r_bout;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_bit;
    logic                 w_brw_nxt;
    logic [WIDTH-1:0]     w_res;

    assign w_accept  = bus.start && (r_state != SHIFT);
    assign w_last    = (r_state == SHIFT) && (r_cnt == c_last);
    assign w_bit     = r_a[0] ^ r_b[0] ^ r_brw;
    assign w_brw_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
    // New bit enters at the top; after the last step this is the full result.
    assign w_res     = {w_bit, r_res};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    w_state_nxt = bus.start ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_brw  <= bus.bin;
            r_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_brw <= w_brw_nxt;
            r_cnt <= r_cnt + 1'b1;
            r_res <= w_res[WIDTH-1:1];
            // On the last step r_a[0]/r_b[0] hold the operand sign bits.
            if (w_last) begin
                r_diff <= w_res;
                r_bout <= w_brw_nxt;
                r_ovf  <= (r_a[0] ^ r_b[0]) & (w_bit ^ r_a[0]);
            end
        end
    end

    assign bus.busy     = (r_state == SHIFT);
    assign bus.done     = (r_state == DONE);
    assign bus.diff     = r_diff;
    assign bus.bout     = r_bout;
    assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor8.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor8
// Description : Self-checking bench for serial_subtractor8 against an
//               arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_subtractor8;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_subtractor8_if #(.WIDTH(W)) bus ();

    serial_subtractor8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {bout, diff} straight from extended-width arithmetic.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rbin);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
        ovf  = (ra[W-1] != rb[W-1]) && (full[W-1] != ra[W-1]);
        return {ovf, full};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input logic [W+1:0] exp);
        check({tag, "_diff"}, 32'(bus.diff), 32'(exp[W-1:0]));
        check({tag, "_bout"}, 32'(bus.bout), 32'(exp[W]));
        check({tag, "_ovf"},  32'(bus.overflow), 32'(exp[W+1]));
    endtask

    // Called just after a rising edge with the DUT not busy; returns just after
    // the edge that raises done.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tbin,
                         input string tag);
        int cyc;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_b;
        bus.bin   = tbin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 2 * W) begin
            check({tag, "_nodone_busy"}, 32'(bus.done), 32'd0);
            cyc++;
            @(posedge clk); #1;
        end
        check({tag, "_busy_cycles"}, 32'(cyc), 32'(W));
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check_results(tag, ref_sub(ta, tb_b, tbin));
    endtask

    logic [W+1:0] exp_q[$];
    logic [W+1:0] held;
    logic [W+1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check_results("rst", '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        do_op(8'h03, 8'h03, 1'b0, "t1");
        check_results("t1_abs", {1'b0, 1'b0, 8'h00});
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(bus.done), 32'd0);
        do_op(8'h80, 8'h01, 1'b0, "t2a");
        check_results("t2a_abs", {1'b1, 1'b0, 8'h7F});
        do_op(8'h03, 8'h07, 1'b0, "t2b");
        check_results("t2b_abs", {1'b0, 1'b1, 8'hFC});
        do_op(8'h7F, 8'hFF, 1'b0, "t3a");
        check_results("t3a_abs", {1'b1, 1'b1, 8'h80});
        do_op(8'h00, 8'h00, 1'b1, "t3b");
        check_results("t3b_abs", {1'b0, 1'b1, 8'hFF});
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check_results("t3b_hold_idle", {1'b0, 1'b1, 8'hFF});

        // start held high, operands churning every cycle: accepts every W+1 edges
        bus.start = 1'b1;
        for (int k = 0; k < 3 * (W + 1); k++) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.bin = 1'($urandom);
            if (k % (W + 1) == 0) exp_q.push_back(ref_sub(bus.a, bus.b, bus.bin));
            @(posedge clk); #1;
            check("t4_done", 32'(bus.done), 32'((k % (W + 1)) == W));
            if (bus.done === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_results("t4", e);
            end
        end
        bus.start = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset during the 4th SHIFT cycle
        do_op(8'h03, 8'h07, 1'b0, "t5_pre");
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h12;
        bus.bin   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_done", 32'(bus.done), 32'd0);
        check_results("t5_rst", '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            check("t5_no_done", 32'(bus.done), 32'd0);
        end
        do_op(8'h55, 8'h12, 1'b0, "t5_post");
        check_results("t5_post_abs", {1'b0, 1'b0, 8'h43});
        @(posedge clk); #1;

        // Random sweep
        for (int n = 0; n < 1000; n++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            do_op(ra, rb, rbin, "rnd");
            held = ref_sub(ra, rb, rbin);
            @(posedge clk); #1;
            check("rnd_done_pulse", 32'(bus.done), 32'd0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            check_results("rnd_hold", held);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
